// File: rtl/msdap_sequencer.sv
// MSDAP control sequencer: memory clear, Rj/coefficient loading, data capture and ALU triggering.
// Optional low-power SLEEP state is built only when MSDAP_SLEEP_EN is defined.
module msdap_sequencer #(
    parameter int RJ_WORDS     = 16,
    parameter int COEFF_WORDS  = 512,
    parameter int DATA_WORDS   = 256,
    parameter int CLEAR_CYCLES = 256,
    localparam int AW = $clog2(COEFF_WORDS),
    localparam int DW = $clog2(DATA_WORDS),
    localparam int CW = $clog2(CLEAR_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_pulse,
    input  logic          cmd_rst_n,
    input  logic          all_zeros,
    output logic [3:0]    state,
    output logic          rj_wen,
    output logic          coeff_wen,
    output logic          data_wen,
    output logic [AW-1:0] wr_addr,
    output logic          clear_mem,
    output logic          alu_start,
    output logic          in_ready,
    output logic          sleep
);

    typedef enum logic [3:0] {
        ST_INIT       = 4'd0,
        ST_WAIT_RJ    = 4'd1,
        ST_READ_RJ    = 4'd2,
        ST_WAIT_COEFF = 4'd3,
        ST_READ_COEFF = 4'd4,
        ST_WAIT_INPUT = 4'd5,
        ST_WORKING    = 4'd6,
        ST_CLEARING   = 4'd7,
        ST_SLEEP      = 4'd8
    } state_e;

    localparam logic [AW-1:0] RJ_LAST    = AW'(RJ_WORDS - 1);
    localparam logic [AW-1:0] COEFF_LAST = AW'(COEFF_WORDS - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLEAR_CYCLES - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] clr_q, clr_d;
    logic          armed_q;
    logic          alu_q, alu_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ptr_q   <= '0;
            clr_q   <= '0;
            armed_q <= 1'b0;
            alu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            clr_q   <= clr_d;
            armed_q <= 1'b1;
            alu_q   <= alu_d;
        end
    end

    // armed_q holds off the INIT clear until the first clock after reset release.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        clr_d     = '0;
        rj_wen    = 1'b0;
        coeff_wen = 1'b0;
        data_wen  = 1'b0;
        wr_addr   = '0;
        in_ready  = 1'b0;
        clear_mem = 1'b0;

        case (state_q)
            ST_INIT: begin
                clear_mem = armed_q;
                cnt_d     = '0;
                ptr_d     = '0;
                if (armed_q) begin
                    if (clr_q == CLR_LAST) begin
                        state_d = ST_WAIT_RJ;
                    end else begin
                        clr_d = clr_q + CW'(1);
                    end
                end
            end

            ST_WAIT_RJ: begin
                in_ready = 1'b1;
                if (frame_pulse) begin
                    rj_wen = 1'b1;
                    if (RJ_WORDS == 1) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_COEFF;
                    end else begin
                        cnt_d   = AW'(1);
                        state_d = ST_READ_RJ;
                    end
                end
            end

            ST_READ_RJ: begin
                in_ready = 1'b1;
                if (frame_pulse) begin
                    rj_wen  = 1'b1;
                    wr_addr = cnt_q;
                    if (cnt_q == RJ_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_COEFF;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end

            ST_WAIT_COEFF: begin
                in_ready = 1'b1;
                if (frame_pulse) begin
                    coeff_wen = 1'b1;
                    if (COEFF_WORDS == 1) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_INPUT;
                    end else begin
                        cnt_d   = AW'(1);
                        state_d = ST_READ_COEFF;
                    end
                end
            end

            ST_READ_COEFF: begin
                in_ready = 1'b1;
                if (frame_pulse) begin
                    coeff_wen = 1'b1;
                    wr_addr   = cnt_q;
                    if (cnt_q == COEFF_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_INPUT;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end

            ST_WAIT_INPUT: begin
                in_ready = 1'b1;
                if (!cmd_rst_n) begin
                    state_d = ST_CLEARING;
                end else if (frame_pulse) begin
                    data_wen = 1'b1;
                    ptr_d    = DW'(1);
                    state_d  = ST_WORKING;
                end
            end

            ST_WORKING: begin
                in_ready = 1'b1;
                if (!cmd_rst_n) begin
                    state_d = ST_CLEARING;
                end else begin
                    if (frame_pulse) begin
                        data_wen = 1'b1;
                        wr_addr  = AW'(ptr_q);
                        ptr_d    = ptr_q + DW'(1);
                    end
`ifdef MSDAP_SLEEP_EN
                    if (all_zeros) begin
                        state_d = ST_SLEEP;
                    end
`endif
                end
            end

            // Counter saturates so a long host clear still exits cleanly once released.
            ST_CLEARING: begin
                clear_mem = 1'b1;
                ptr_d     = '0;
                if (clr_q == CLR_LAST) begin
                    if (cmd_rst_n) begin
                        state_d = ST_WAIT_INPUT;
                    end else begin
                        clr_d = clr_q;
                    end
                end else begin
                    clr_d = clr_q + CW'(1);
                end
            end

`ifdef MSDAP_SLEEP_EN
            ST_SLEEP: begin
                in_ready = 1'b1;
                if (!cmd_rst_n) begin
                    state_d = ST_CLEARING;
                end else begin
                    if (frame_pulse) begin
                        data_wen = 1'b1;
                        wr_addr  = AW'(ptr_q);
                        ptr_d    = ptr_q + DW'(1);
                    end
                    if (!all_zeros) begin
                        state_d = ST_WORKING;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
                ptr_d   = '0;
            end
        endcase
    end

    // Writes landing while staying asleep do not trigger the ALU.
    assign alu_d     = data_wen && (state_d != ST_SLEEP);
    assign alu_start = alu_q;
    assign state     = state_q;

`ifdef MSDAP_SLEEP_EN
    assign sleep = (state_q == ST_SLEEP);
`else
    logic unused_all_zeros;
    assign unused_all_zeros = all_zeros;
    assign sleep            = 1'b0;
`endif

endmodule

// File: tb/tb_msdap_sequencer.sv
// Directed bench for msdap_sequencer: init clear, Rj/coeff loads, data wrap, host clear, sleep, reset mid-load.
module tb_msdap_sequencer;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_pulse;
    logic          cmd_rst_n;
    logic          all_zeros;
    logic [3:0]    state;
    logic          rj_wen, coeff_wen, data_wen;
    logic [AW-1:0] wr_addr;
    logic          clear_mem, alu_start, in_ready, sleep;

    int errors = 0;
    int checks = 0;

    logic [3:0]    s_state;
    logic          s_rj, s_coeff, s_data, s_clear, s_alu, s_ready, s_sleep;
    logic [AW-1:0] s_addr;

    always #5 clk = ~clk;

    msdap_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_pulse(frame_pulse),
        .cmd_rst_n  (cmd_rst_n),
        .all_zeros  (all_zeros),
        .state      (state),
        .rj_wen     (rj_wen),
        .coeff_wen  (coeff_wen),
        .data_wen   (data_wen),
        .wr_addr    (wr_addr),
        .clear_mem  (clear_mem),
        .alu_start  (alu_start),
        .in_ready   (in_ready),
        .sleep      (sleep)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle: apply inputs, snapshot outputs mid-cycle, advance past the edge.
    task automatic step(input logic fp, input logic cmd, input logic az);
        frame_pulse = fp;
        cmd_rst_n   = cmd;
        all_zeros   = az;
        #1;
        s_state = state;
        s_rj    = rj_wen;
        s_coeff = coeff_wen;
        s_data  = data_wen;
        s_addr  = wr_addr;
        s_clear = clear_mem;
        s_alu   = alu_start;
        s_ready = in_ready;
        s_sleep = sleep;
        @(posedge clk);
        #1;
    endtask

    // Runs INIT with frame_pulse held high; measures the clear window.
    task automatic wait_init(output int clr_cnt, output int first_clear, output int stray, output bit done);
        clr_cnt     = 0;
        first_clear = -1;
        stray       = 0;
        done        = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (s_rj || s_coeff || s_data) stray++;
            if (s_state == 4'd0 && s_clear) begin
                clr_cnt++;
                if (first_clear < 0) first_clear = i;
            end
            if (state == 4'd1) done = 1'b1;
        end
    endtask

    initial begin
        int  clr_cnt, first_clear, stray, cnt7, bad;
        bit  done;
        int  exp_ptr;

        rst_n       = 1'b0;
        frame_pulse = 1'b0;
        cmd_rst_n   = 1'b1;
        all_zeros   = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, frame_pulse asserted while held in reset
        step(1'b1, 1'b1, 1'b0);
        chk("rst_state", s_state, 0);
        chk("rst_clear", s_clear, 0);
        chk("rst_strobes", {s_rj, s_coeff, s_data, s_alu}, 0);
        chk("rst_sleep", s_sleep, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_addr", s_addr, 0);

        // Init clear: 256 cycles, first clock after release, pulses ignored
        rst_n = 1'b1;
        wait_init(clr_cnt, first_clear, stray, done);
        chk("init_done", done, 1);
        chk("init_clear_len", clr_cnt, 256);
        chk("init_first_clear", first_clear, 1);
        chk("init_no_write", stray, 0);
        chk("init_exit_state", state, 1);
        chk("init_exit_ready", in_ready, 1);
        chk("init_exit_clear", clear_mem, 0);

        // Rj load with cmd_rst_n low (ignored here)
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0);
            $display("rj    wen=%0d addr=%0d", s_rj, s_addr);
            chk("rj_wen", {s_rj, s_coeff, s_data}, 3'b100);
            chk("rj_addr", s_addr, i);
            if (i == 0) chk("rj_state_read", state, 2);
        end
        chk("rj_done_state", state, 3);

        step(1'b0, 1'b1, 1'b0);
        chk("idle_addr", s_addr, 0);
        chk("idle_strobes", {s_rj, s_coeff, s_data}, 0);
        chk("idle_state", state, 3);

        for (int i = 0; i < 512; i++) begin
            step(1'b1, 1'b1, 1'b0);
            $display("coeff wen=%0d addr=%0d", s_coeff, s_addr);
            chk("coeff_wen", {s_rj, s_coeff, s_data}, 3'b010);
            chk("coeff_addr", s_addr, i);
        end
        chk("coeff_done_state", state, 5);

        // Data capture: 257 writes wrap 0..255,0, each followed by alu_start
        exp_ptr = 0;
        for (int k = 0; k < 257; k++) begin
            step(1'b1, 1'b1, 1'b0);
            $display("data  wen=%0d addr=%0d", s_data, s_addr);
            chk("data_wen", {s_rj, s_coeff, s_data}, 3'b001);
            chk("data_addr", s_addr, exp_ptr);
            chk("alu_not_early", s_alu, 0);
            exp_ptr = (exp_ptr + 1) % 256;
            if (k == 0) chk("working_state", state, 6);
            step(1'b0, 1'b1, 1'b0);
            chk("alu_after_data", s_alu, 1);
            chk("gap_no_write", s_data, 0);
        end

`ifdef MSDAP_SLEEP_EN
        step(1'b0, 1'b1, 1'b1);
        chk("sleep_state", state, 8);
        chk("sleep_flag", sleep, 1);
        step(1'b1, 1'b1, 1'b1);
        chk("sleep_data_wen", s_data, 1);
        chk("sleep_data_addr", s_addr, exp_ptr);
        exp_ptr = (exp_ptr + 1) % 256;
        chk("sleep_stay", state, 8);
        step(1'b0, 1'b1, 1'b1);
        chk("sleep_no_alu", s_alu, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("wake_data_wen", s_data, 1);
        chk("wake_data_addr", s_addr, exp_ptr);
        exp_ptr = (exp_ptr + 1) % 256;
        chk("wake_state", state, 6);
        step(1'b0, 1'b1, 1'b0);
        chk("wake_alu", s_alu, 1);
        chk("wake_sleep_flag", s_sleep, 0);
`else
        step(1'b1, 1'b1, 1'b1);
        chk("az_ignored_wen", s_data, 1);
        chk("az_ignored_addr", s_addr, exp_ptr);
        exp_ptr = (exp_ptr + 1) % 256;
        chk("az_ignored_state", state, 6);
        chk("az_ignored_sleep", sleep, 0);
        step(1'b0, 1'b1, 1'b1);
        chk("az_ignored_alu", s_alu, 1);
        all_zeros = 1'b0;
`endif

        // Host clear for 300 cycles, coinciding with a frame_pulse
        step(1'b1, 1'b0, 1'b0);
        chk("clr_cmd_no_write", s_data, 0);
        chk("clr_enter_state", state, 7);
        cnt7 = 0;
        bad  = 0;
        for (int i = 1; i < 300; i++) begin
            step(logic'(i % 2), 1'b0, 1'b0);
            if (s_state == 4'd7) cnt7++;
            if (s_rj || s_coeff || s_data || !s_clear || s_ready) bad++;
        end
        step(1'b1, 1'b1, 1'b0);
        if (s_state == 4'd7) cnt7++;
        if (s_rj || s_coeff || s_data || !s_clear || s_ready) bad++;
        chk("clr_cycles", cnt7, 300);
        chk("clr_outputs", bad, 0);
        chk("clr_exit_state", state, 5);
        step(1'b1, 1'b1, 1'b0);
        chk("post_clr_addr0", s_addr, 0);
        chk("post_clr_wen", s_data, 1);
        step(1'b1, 1'b1, 1'b0);
        chk("post_clr_addr1", s_addr, 1);
        chk("post_clr_alu", s_alu, 1);

        // Short host clear: CLEARING still lasts the full 256 cycles
        step(1'b0, 1'b0, 1'b0);
        cnt7 = 0;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (s_state == 4'd7) cnt7++;
            if (state == 4'd5) done = 1'b1;
        end
        chk("short_clr_done", done, 1);
        chk("short_clr_cycles", cnt7, 256);

        // cmd_rst_n low in WAIT_INPUT with a pulse
        step(1'b1, 1'b0, 1'b0);
        chk("wi_cmd_no_write", s_data, 0);
        chk("wi_cmd_state", state, 7);

        // Reset mid-load discards progress
        rst_n = 1'b0;
        #1;
        chk("rst2_state", state, 0);
        chk("rst2_clear", clear_mem, 0);
        rst_n = 1'b1;
        wait_init(clr_cnt, first_clear, stray, done);
        chk("init2_done", done, 1);
        chk("init2_clear_len", clr_cnt, 256);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            $display("rj    wen=%0d addr=%0d", s_rj, s_addr);
        end
        chk("midload_addr", s_addr, 4);
        frame_pulse = 1'b1;
        rst_n       = 1'b0;
        #1;
        chk("rst3_state", state, 0);
        chk("rst3_strobes", {rj_wen, coeff_wen, data_wen}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init(clr_cnt, first_clear, stray, done);
        chk("init3_done", done, 1);
        chk("init3_first_clear", first_clear, 1);
        step(1'b1, 1'b1, 1'b0);
        chk("reload_rj_wen", s_rj, 1);
        chk("reload_rj_addr", s_addr, 0);
        chk("reload_state", state, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
